// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one aligned 8-byte I-cache
// request in flight and presents the fetched, predictor-annotated window to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] INST_NOP = 32'h03400000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        set_pc,
    input  logic [31:0] set_pc_target,
    input  logic        id_full,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [63:0] icache_resp_data,
    output logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic        pred_slot,
    input  logic [31:0] pred_target,
    input  logic        pred_unknown0,
    input  logic        pred_unknown1,
    output logic        out_valid,
    output logic [31:0] inst0,
    output logic [31:0] inst1,
    output logic [31:0] pc_out,
    output logic [31:0] pc_next_out,
    output logic        unknown0,
    output logic        unknown1,
    output logic        first_inst_jmp
);

    // state  | meaning
    // REQ    | requesting the window at pc
    // WAIT   | request accepted, waiting for the response
    // OUT    | window held for decode until it is taken
    // DROP   | waiting for a response orphaned by a redirect
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] fnext_q, fnext_d;
    logic        ftaken_q, ftaken_d;
    logic        fslot_q, fslot_d;
    logic [1:0]  funk_q, funk_d;
    logic [63:0] data_q, data_d;

    logic [28:0] seq_hi;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic [31:0] redirect_pc;
    logic        pred_use;
    logic        xfer;
    logic        redirect;

    assign seq_hi = pc_q[31:3] + 29'd1;
    assign seq_pc = {seq_hi, 3'b000};
    // A slot-0 hit is meaningless when fetch entered the window at its second word.
    assign pred_use = pred_taken && !(!pred_slot && pc_q[2]);
    assign next_pc  = pred_use ? pred_target : seq_pc;

    assign icache_req_valid = (state_q == S_REQ) && !flush;
    assign icache_req_addr  = {pc_q[31:3], 3'b000};
    assign pred_pc          = pc_q;

    assign out_valid      = (state_q == S_OUT) && !flush;
    assign inst0          = data_q[31:0];
    assign inst1          = data_q[63:32];
    assign pc_out         = fpc_q;
    assign pc_next_out    = fnext_q;
    assign unknown0       = funk_q[0];
    assign unknown1       = funk_q[1];
    assign first_inst_jmp = ftaken_q && !fslot_q && !fpc_q[2];

    assign xfer        = out_valid && !id_full;
    assign redirect    = flush || (set_pc && xfer);
    assign redirect_pc = flush ? flush_target : set_pc_target;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fpc_d    = fpc_q;
        fnext_d  = fnext_q;
        ftaken_d = ftaken_q;
        fslot_d  = fslot_q;
        funk_d   = funk_q;
        data_d   = data_q;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = icache_req_ready ? S_DROP : S_REQ;
                end else if (icache_req_ready) begin
                    fpc_d    = pc_q;
                    fnext_d  = next_pc;
                    ftaken_d = pred_taken;
                    fslot_d  = pred_slot;
                    funk_d   = {pred_unknown1, pred_unknown0};
                    pc_d     = next_pc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = icache_resp_valid ? S_REQ : S_DROP;
                end else if (icache_resp_valid) begin
                    data_d  = icache_resp_data;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (xfer) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                // The orphaned response is consumed even if a new redirect lands with it.
                if (icache_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            fpc_q    <= RESET_PC;
            fnext_q  <= RESET_PC + 32'd8;
            ftaken_q <= 1'b0;
            fslot_q  <= 1'b0;
            funk_q   <= 2'b00;
            data_q   <= {INST_NOP, INST_NOP};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fpc_q    <= fpc_d;
            fnext_q  <= fnext_d;
            ftaken_q <= ftaken_d;
            fslot_q  <= fslot_d;
            funk_q   <= funk_d;
            data_q   <= data_d;
        end
    end

endmodule
